// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Pipeline hazard controller for the 5-stage ARM core. It drives the
//   stall, flush and bubble enables of the PC, IF/ID, ID/EX, EX/MEM and
//   MEM/WB registers. It resolves the hazards that operand forwarding cannot
//   cover:
//     - load-use stalls
//     - taken-branch flushes
//     - multi-cycle multiply occupancy of EX
//     - a global freeze while data memory is waiting
//   Operand bypass itself lives in the forwarding unit.
//
// Parameters:
//   MUL_LATENCY  cycles a multiply occupies EX (1..15)
//   CNT_W        width of the multiply occupancy counter
//
// Ports:
//   clk              core clock, rising edge
//   rst_n            synchronous active-low reset
//   rn_ifid          source reg 1 of the ID instruction
//   rm_ifid          source reg 2 of the ID instruction
//   uses_rn_ifid     ID instruction reads rn
//   uses_rm_ifid     ID instruction reads rm
//   rd_idex          destination of the EX instruction
//   mem_read_idex    EX instruction is a load
//   mul_idex         EX instruction is a multiply
//   branch_taken_ex  branch in EX resolved taken
//   mem_wait         data memory not ready (freeze)
//   pc_stall         hold PC
//   ifid_stall       hold IF/ID
//   ifid_flush       zero IF/ID
//   idex_stall       hold ID/EX
//   idex_bubble      load NOP into ID/EX
//   exmem_bubble     load NOP into EX/MEM
//   memwb_stall      hold MEM/WB
//   mul_busy         FSM is in MUL_BUSY
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   Adds the saturating 32-bit counters stall_cycles, flush_count and
//   loaduse_count. They are cleared by reset. Without the macro, the ports
//   and the counters do not exist.
// -----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       rn_ifid,
  input  logic [3:0]       rm_ifid,
  input  logic             uses_rn_ifid,
  input  logic             uses_rm_ifid,
  input  logic [3:0]       rd_idex,
  input  logic             mem_read_idex,
  input  logic             mul_idex,
  input  logic             branch_taken_ex,
  input  logic             mem_wait,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_stall,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count,
  output logic [31:0]      loaduse_count,
`endif
  output logic             mul_busy
);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  // A single-cycle multiply never needs to hold EX.
  localparam bit MUL_HOLD_EN = (MUL_LATENCY > 1);

  // The first hold cycle happens in IDLE, and the last EX cycle is a
  // no-hold cycle in MUL_BUSY. So the counter starts at MUL_LATENCY-2.
  localparam int              LOAD_VAL = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic load_use;
  logic mul_start;
  logic mul_hold;
  logic branch_flush;
  logic load_use_stall;

  // Hazard detection. r0 as a destination never creates a dependency.
  always_comb begin
    load_use = mem_read_idex && (rd_idex != 4'd0) &&
               ((uses_rn_ifid && (rn_ifid == rd_idex)) ||
                (uses_rm_ifid && (rm_ifid == rd_idex)));

    mul_start = (state == IDLE) && mul_idex && MUL_HOLD_EN;

    mul_hold = mul_start || ((state == MUL_BUSY) && (cnt != '0));

    // The branch outranks load-use because the ID instruction is on the
    // wrong path. The last multiply cycle in MUL_BUSY suppresses both checks.
    branch_flush = (state == IDLE) && !mul_start && branch_taken_ex;

    load_use_stall = (state == IDLE) && !mul_start && !branch_taken_ex && load_use;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. A memory wait freezes both the state and the counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!mem_wait) begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state_next = MUL_BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output logic. While in reset, every output is zero.
  // A memory wait overrides every other hazard.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_stall  = 1'b0;
    mul_busy     = 1'b0;
    if (rst_n) begin
      if (mem_wait) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        memwb_stall = 1'b1;
      end else begin
        mul_busy = (state == MUL_BUSY);
        if (mul_hold) begin
          // Hold the multiply in EX and feed a NOP into MEM behind it.
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idex_stall   = 1'b1;
          exmem_bubble = 1'b1;
        end else if (branch_flush) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use_stall) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters. Each one saturates instead of wrapping.
  // Flush and load-use events do not count during a memory freeze, because
  // they are not acted on in that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      flush_count   <= '0;
      loaduse_count <= '0;
    end else begin
      if (pc_stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
      if (load_use_stall && !mem_wait && (loaduse_count != 32'hFFFF_FFFF))
        loaduse_count <= loaduse_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Purpose:
//   Directed, scoreboard-based bench for hazard_control_unit with
//   MUL_LATENCY=3.
//   - The driver applies one input vector per cycle and pushes the expected
//     output vector (computed by hand) into a queue.
//   - A monitor samples the outputs on the falling edge and compares them
//     against the queue.
//   With HAZARD_PERF_CNT_EN defined, the bench also checks the counters.
//
// Expected vector bit order:
//   {pc_stall, ifid_stall, ifid_flush, idex_stall,
//    idex_bubble, exmem_bubble, memwb_stall, mul_busy}
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] rn_ifid, rm_ifid, rd_idex;
  logic       uses_rn_ifid, uses_rm_ifid;
  logic       mem_read_idex, mul_idex, branch_taken_ex, mem_wait;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall;
  logic       idex_bubble, exmem_bubble, memwb_stall, mul_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, loaduse_count;
`endif

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] E_NONE      = 8'b0000_0000;
  localparam logic [7:0] E_HOLD      = 8'b1101_0100;
  localparam logic [7:0] E_HOLD_BUSY = 8'b1101_0101;
  localparam logic [7:0] E_BUSY      = 8'b0000_0001;
  localparam logic [7:0] E_LU        = 8'b1100_1000;
  localparam logic [7:0] E_BR        = 8'b0010_1000;
  localparam logic [7:0] E_MW        = 8'b1101_0010;

  hazard_control_unit #(
    .MUL_LATENCY(3),
    .CNT_W      (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rn_ifid        (rn_ifid),
    .rm_ifid        (rm_ifid),
    .uses_rn_ifid   (uses_rn_ifid),
    .uses_rm_ifid   (uses_rm_ifid),
    .rd_idex        (rd_idex),
    .mem_read_idex  (mem_read_idex),
    .mul_idex       (mul_idex),
    .branch_taken_ex(branch_taken_ex),
    .mem_wait       (mem_wait),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_stall     (idex_stall),
    .idex_bubble    (idex_bubble),
    .exmem_bubble   (exmem_bubble),
    .memwb_stall    (memwb_stall),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count),
    .loaduse_count  (loaduse_count),
`endif
    .mul_busy       (mul_busy)
  );

  // 10 ns clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge, and queue the
  // response the outputs should show for that cycle.
  task automatic applyStimulus(
    input logic       rst, mul, br, mw, memr,
    input logic [3:0] rd, rn, rm,
    input logic       urn, urm,
    input logic [7:0] exp,
    input string      name
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rst;
    mul_idex        = mul;
    branch_taken_ex = br;
    mem_wait        = mw;
    mem_read_idex   = memr;
    rd_idex         = rd;
    rn_ifid         = rn;
    rm_ifid         = rm;
    uses_rn_ifid    = urn;
    uses_rm_ifid    = urm;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Compare the sampled outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {pc_stall, ifid_stall, ifid_flush, idex_stall,
           idex_bubble, exmem_bubble, memwb_stall, mul_busy};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.exp);
    end
  endtask

  // Monitor: one output vector per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Let the monitor empty the scoreboard, with a bounded wait.
  task automatic drain(input string tag);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d entries left, 0 required", tag, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; mul_idex = 1'b0; branch_taken_ex = 1'b0; mem_wait = 1'b0;
    mem_read_idex = 1'b0; rd_idex = 4'd0; rn_ifid = 4'd0; rm_ifid = 4'd0;
    uses_rn_ifid = 1'b0; uses_rm_ifid = 1'b0;

    // Reset with active hazards on the inputs
    //            rst mul br mw mr rd    rn    rm    urn urm
    applyStimulus(0, 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "reset_c0");
    applyStimulus(0, 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "reset_c1");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "after_reset");

    // Load-use on rm, then the condition clears
    applyStimulus(1, 0, 0, 0, 1, 4'd3, 4'd0, 4'd3, 0, 1, E_LU,   "loaduse_rm");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd3, 0, 1, E_NONE, "loaduse_clear");
    // r0 destination never stalls
    applyStimulus(1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 1, 1, E_NONE, "loaduse_r0");
    // Load-use on rn; a register that is not read does not stall
    applyStimulus(1, 0, 0, 0, 1, 4'd5, 4'd5, 4'd2, 1, 1, E_LU,   "loaduse_rn");
    applyStimulus(1, 0, 0, 0, 1, 4'd5, 4'd5, 4'd2, 0, 1, E_NONE, "loaduse_unused_rn");
    applyStimulus(1, 0, 0, 0, 0, 4'd5, 4'd5, 4'd5, 1, 1, E_NONE, "no_load");

    // Multiply back-to-back. The branch is ignored during the hold, and the
    // last MUL_BUSY cycle ignores every other hazard.
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_HOLD,      "mul1_c0");
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_HOLD_BUSY, "mul1_c1");
    applyStimulus(1, 1, 1, 0, 1, 4'd4, 4'd4, 4'd0, 1, 0, E_BUSY,      "mul1_c2");
    applyStimulus(1, 1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_HOLD,      "mul2_c0_branch");
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_HOLD_BUSY, "mul2_c1");
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_BUSY,      "mul2_c2");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE,      "mul_done");

    // Branch outranks load-use
    applyStimulus(1, 0, 1, 0, 1, 4'd3, 4'd0, 4'd3, 0, 1, E_BR,   "branch_vs_loaduse");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "branch_done");

    // Memory wait while in MUL_BUSY with cnt=1 stretches EX to 5 cycles
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_HOLD,      "mw_mul_c0");
    applyStimulus(1, 1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_MW,        "mw_mul_c1");
    applyStimulus(1, 1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_MW,        "mw_mul_c2");
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_HOLD_BUSY, "mw_mul_c3");
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_BUSY,      "mw_mul_c4");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE,      "mw_mul_done");

    // Memory wait overrides load-use and branch in IDLE
    applyStimulus(1, 0, 1, 1, 1, 4'd3, 4'd3, 4'd0, 1, 0, E_MW,   "mw_idle");

    // Reset mid-multiply drops the pending hold
    applyStimulus(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_HOLD, "rst_mul_c0");
    applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "rst_mul_in_reset");
    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "rst_mul_after");
    drain("drain_main");

`ifdef HAZARD_PERF_CNT_EN
    // 4 load-use events and 2 flushes after a fresh reset
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "perf_reset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 4'd7, 4'd7, 4'd0, 1, 0, E_LU,   "perf_lu");
      applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "perf_idle");
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_BR,   "perf_br");
      applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, E_NONE, "perf_idle");
    end
    drain("drain_perf");
    @(negedge clk);
    checks++;
    if (loaduse_count !== 32'd4) begin
      errors++;
      $display("[TB] FAIL loaduse_count: got %0d expected 4", loaduse_count);
    end
    checks++;
    if (flush_count !== 32'd2) begin
      errors++;
      $display("[TB] FAIL flush_count: got %0d expected 2", flush_count);
    end
    checks++;
    if (stall_cycles !== 32'd4) begin
      errors++;
      $display("[TB] FAIL stall_cycles: got %0d expected 4", stall_cycles);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage ARM core. It sits upstream of the EX-stage forwarding logic and drives the stall, flush and bubble enables of the PC, IF/ID, ID/EX and EX/MEM registers.
- Covers four cases: load-use stalls, taken-branch flushes, multi-cycle multiply occupancy of EX, and global freeze on data-memory wait.
- Operand bypass stays in the forwarding unit; this block only resolves the hazards forwarding cannot cover.

Parameters:
- MUL_LATENCY, 3, cycles a multiply occupies EX (legal range 1..15).
- CNT_W, 4, width of the multiply occupancy counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- rn_ifid  in  4  source reg 1 of the instruction in ID.
- rm_ifid  in  4  source reg 2 of the instruction in ID.
- uses_rn_ifid  in  1  ID instruction reads rn.
- uses_rm_ifid  in  1  ID instruction reads rm.
- rd_idex  in  4  destination of the instruction in EX.
- mem_read_idex  in  1  EX instruction is a load.
- mul_idex  in  1  EX instruction is a multiply.
- branch_taken_ex  in  1  branch in EX resolved taken.
- mem_wait  in  1  data memory not ready; freeze the pipeline.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID (becomes NOP).
- idex_stall  out  1  hold ID/EX.
- idex_bubble  out  1  load NOP into ID/EX (all write/mem enables 0).
- exmem_bubble  out  1  load NOP into EX/MEM.
- memwb_stall  out  1  hold MEM/WB.
- mul_busy  out  1  FSM in MUL_BUSY (debug/status).

Behaviour:
- Clocking: single clock domain `clk`. `rst_n` is synchronous, active-low.
- Reset: while `rst_n`=0, all outputs are forced to 0. At the clock edge, state goes to IDLE and cnt to 0.
- FSM states: IDLE, MUL_BUSY. State and cnt are registered; all outputs are combinational from state, cnt and inputs (zero latency).
- mem_wait=1 (highest priority):
  - pc_stall, ifid_stall, idex_stall and memwb_stall are all 1; exmem_bubble=0.
  - All other outputs are 0.
  - State and cnt are frozen (no transition, no decrement).
- IDLE, mul_idex=1, MUL_LATENCY>1 (the EX hold):
  - pc_stall, ifid_stall and idex_stall are 1; exmem_bubble=1.
  - Next state MUL_BUSY, cnt <= MUL_LATENCY-2.
  - branch_taken_ex is ignored.
- IDLE, MUL_LATENCY=1: mul_idex causes no action.
- MUL_BUSY, cnt!=0: EX hold asserted; cnt decrements.
- MUL_BUSY, cnt==0: no hold, so the multiply advances this cycle. Next state IDLE. mul_idex and all other hazard checks are ignored this cycle.
- Net effect: a multiply spends exactly MUL_LATENCY cycles in EX with MUL_LATENCY-1 hold cycles. Back-to-back multiplies re-enter MUL_BUSY with no gap cycle.
- IDLE, branch_taken_ex=1 (no mul hold): ifid_flush=1, idex_bubble=1, PC not stalled. The branch outranks load-use, because the ID instruction is wrong-path.
- IDLE, load-use: condition is mem_read_idex && rd_idex!=0 && ((uses_rn_ifid && rn_ifid==rd_idex) || (uses_rm_ifid && rm_ifid==rd_idex)).
  - pc_stall=1, ifid_stall=1, idex_bubble=1 for exactly one cycle.
  - On the next cycle the load is in MEM, the condition clears, and forwarding from MEM/WB covers the operand.
- r0 convention: a destination of 0 never triggers a hazard, matching the forwarding unit's r0 convention.
- Illegal combinations: stall and flush on the same register are never both asserted. idex_stall and idex_bubble are never both 1.
- Reset mid-multiply: state returns to IDLE and the pending hold is dropped.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, each saturating at 0xFFFFFFFF and cleared by reset:
  - stall_cycles: cycles with pc_stall=1.
  - flush_count: branch flushes.
  - loaduse_count: load-use stalls.
- When undefined, these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with mul_idex=1 and branch_taken_ex=1 -> all outputs 0; after release with inputs 0, state IDLE and mul_busy=0.
- Load-use: mem_read_idex=1, rd_idex=3, rm_ifid=3, uses_rm_ifid=1 -> pc_stall, ifid_stall and idex_bubble are 1 for one cycle; with rd_idex=0 instead -> no stall.
- Multiply, MUL_LATENCY=3: mul_idex=1 in cycle 0 -> hold in cycles 0-1, none in cycle 2, mul_busy=1 in cycles 1-2; a second mul_idex in cycle 3 repeats the pattern.
- Branch vs load-use: branch_taken_ex=1 with a load-use match present -> ifid_flush=1, idex_bubble=1, pc_stall=0.
- mem_wait during multiply: assert mem_wait for 2 cycles in MUL_BUSY with cnt=1 -> all four stalls 1, cnt frozen; after release the hold resumes, so total EX occupancy is 5 cycles.
- HAZARD_PERF_CNT_EN defined: 4 load-use events and 2 flushes -> loaduse_count=4, flush_count=2, stall_cycles=4.
